click_decoder: RTL and testbench



---
 rtl/click_decoder_if.sv | 19 +
 rtl/click_decoder.sv | 126 ++++++++++++
 tb/tb_click_decoder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/click_decoder_if.sv
// Click event handshake between click_decoder and its consumer.
// master drives the completed group; slave accepts it with click_ready.
interface click_decoder_if;
    logic       click_valid;
    logic [2:0] click_count;
    logic       click_ready;

    modport master (
        output click_valid,
        output click_count,
        input  click_ready
    );

    modport slave (
        input  click_valid,
        input  click_count,
        output click_ready
    );
endinterface

// File: rtl/click_decoder.sv
// Groups debounced press pulses into single/double/triple... click events.
// Optional CLICK_DECODER_DROP_CNT_EN adds a saturating dropped-press counter.
module click_decoder #(
    parameter int WINDOW     = 20,
    parameter int MAX_CLICKS = 3,
    parameter int TMR_W      = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             press,
    output logic             busy,
`ifdef CLICK_DECODER_DROP_CNT_EN
    output logic [7:0]       drop_cnt,
    input  logic             drop_clr,
`endif
    click_decoder_if.master  cif
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    localparam logic [2:0]       MAXC   = 3'(MAX_CLICKS);
    localparam logic [TMR_W-1:0] RELOAD = TMR_W'(WINDOW - 1);

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [2:0]       count;
    logic             xfer;

    assign xfer = cif.click_valid & cif.click_ready;

    // Saturation and MAX_CLICKS=1 enter HOLD with valid still low;
    // HOLD raises it one edge later. Window expiry raises it on entry.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= IDLE;
            timer           <= '0;
            count           <= '0;
            busy            <= 1'b0;
            cif.click_valid <= 1'b0;
            cif.click_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (press) begin
                        count <= 3'd1;
                        busy  <= 1'b1;
                        if (MAXC == 3'd1) begin
                            state <= HOLD;
                        end else begin
                            state <= COLLECT;
                            timer <= RELOAD;
                        end
                    end
                end
                COLLECT: begin
                    if (press) begin
                        if (count + 3'd1 == MAXC) begin
                            state <= HOLD;
                            count <= MAXC;
                        end else begin
                            count <= count + 3'd1;
                            timer <= RELOAD;
                        end
                    end else if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else begin
                        state           <= HOLD;
                        cif.click_valid <= 1'b1;
                        cif.click_count <= count;
                    end
                end
                HOLD: begin
                    if (!cif.click_valid) begin
                        cif.click_valid <= 1'b1;
                        cif.click_count <= count;
                    end else if (cif.click_ready) begin
                        cif.click_valid <= 1'b0;
                        cif.click_count <= '0;
                        if (press) begin
                            count <= 3'd1;
                            if (MAXC == 3'd1) begin
                                state <= HOLD;
                            end else begin
                                state <= COLLECT;
                                timer <= RELOAD;
                            end
                        end else begin
                            state <= IDLE;
                            count <= '0;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLICK_DECODER_DROP_CNT_EN
    logic dropped;

    assign dropped = press & (state == HOLD) & ~xfer;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            drop_cnt <= '0;
        end else if (drop_clr) begin
            drop_cnt <= '0;
        end else if (dropped && drop_cnt != 8'hff) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    logic unused_xfer;

    assign unused_xfer = xfer;
`endif

endmodule

// File: tb/tb_click_decoder.sv
// Scoreboard bench for click_decoder with WINDOW=4, MAX_CLICKS=3.
// Expected events (count, rising edge) are queued as presses are scheduled.
module tb_click_decoder;

    localparam int WINDOW     = 4;
    localparam int MAX_CLICKS = 3;

    typedef struct {
        int cnt;
        int edge_no;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic press = 1'b0;
    logic busy;
`ifdef CLICK_DECODER_DROP_CNT_EN
    logic [7:0] drop_cnt;
    logic       drop_clr = 1'b0;
`endif

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic pv = 1'b0;

    click_decoder_if cif ();

    click_decoder #(
        .WINDOW    (WINDOW),
        .MAX_CLICKS(MAX_CLICKS),
        .TMR_W     (16)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .press   (press),
        .busy    (busy),
`ifdef CLICK_DECODER_DROP_CNT_EN
        .drop_cnt(drop_cnt),
        .drop_clr(drop_clr),
`endif
        .cif     (cif.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at edge %0d",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic at_edge(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic before_edge(input int e);
        while (cyc < e - 1) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    task automatic pulse(input int e);
        before_edge(e);
        press = 1'b1;
        at_edge(e);
        press = 1'b0;
    endtask

    task automatic expect_ev(input int cnt, input int e);
        exp_t x;
        x.cnt = cnt;
        x.edge_no = e;
        exp_q.push_back(x);
    endtask

    // Scoreboard monitor: every rising click_valid pops one expectation.
    always begin
        @(posedge clk);
        #1;
        if (cif.click_valid && !pv) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 1, 0);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check("ev_count", int'(cif.click_count), x.cnt);
                check("ev_edge", cyc, x.edge_no);
            end
        end
        if (!cif.click_valid)
            check("count_zero_idle", int'(cif.click_count), 0);
        pv = cif.click_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at edge %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int b;
        cif.click_ready = 1'b1;
        at_edge(3);
        check("rst_valid", int'(cif.click_valid), 0);
        check("rst_count", int'(cif.click_count), 0);
        check("rst_busy", int'(busy), 0);
`ifdef CLICK_DECODER_DROP_CNT_EN
        check("rst_drop", int'(drop_cnt), 0);
`endif
        before_edge(4);
        resetn = 1'b1;
        at_edge(4);

        // single press
        b = cyc + 3;
        expect_ev(1, b + 4);
        pulse(b);
        at_edge(b + 1);
        check("single_busy", int'(busy), 1);
        at_edge(b + 3);
        check("single_not_yet", int'(cif.click_valid), 0);
        at_edge(b + 5);
        check("single_xfer", int'(cif.click_valid), 0);
        check("single_idle", int'(busy), 0);

        // two presses inside the window
        b = cyc + 3;
        expect_ev(2, b + 7);
        pulse(b);
        pulse(b + 3);
        at_edge(b + 9);

        // gap of 5: second press lands on the transfer edge
        b = cyc + 3;
        expect_ev(1, b + 4);
        expect_ev(1, b + 9);
        pulse(b);
        pulse(b + 5);
        check("coinc_busy", int'(busy), 1);
        check("coinc_valid", int'(cif.click_valid), 0);
        at_edge(b + 11);

        // saturation
        b = cyc + 3;
        expect_ev(3, b + 5);
        pulse(b);
        pulse(b + 2);
        pulse(b + 4);
        at_edge(b + 7);

        // back-pressure with dropped presses
        b = cyc + 3;
        expect_ev(1, b + 4);
        cif.click_ready = 1'b0;
        pulse(b);
        at_edge(b + 4);
        for (int k = b + 5; k <= b + 13; k++) begin
            before_edge(k);
            press = (k == b + 6) || (k == b + 9);
            at_edge(k);
            press = 1'b0;
            check("hold_valid", int'(cif.click_valid), 1);
            check("hold_count", int'(cif.click_count), 1);
        end
        before_edge(b + 14);
        cif.click_ready = 1'b1;
        at_edge(b + 14);
        check("hold_xfer", int'(cif.click_valid), 0);
        check("hold_busy", int'(busy), 0);
`ifdef CLICK_DECODER_DROP_CNT_EN
        check("drop_cnt", int'(drop_cnt), 2);
        before_edge(b + 15);
        drop_clr = 1'b1;
        at_edge(b + 15);
        drop_clr = 1'b0;
        check("drop_clr", int'(drop_cnt), 0);
`endif

        // reset while collecting two presses
        b = cyc + 3;
        pulse(b);
        pulse(b + 2);
        before_edge(b + 3);
        resetn = 1'b0;
        at_edge(b + 3);
        resetn = 1'b1;
        check("mid_rst_valid", int'(cif.click_valid), 0);
        check("mid_rst_count", int'(cif.click_count), 0);
        check("mid_rst_busy", int'(busy), 0);
        expect_ev(1, b + 14);
        pulse(b + 10);
        at_edge(b + 16);

        at_edge(cyc + 5);
        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
